// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the pipeline controller state encoding
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} ctrl_state_t;
endpackage

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: stage status inputs and register control strobes between controller and datapath
interface pipeline_controller_if;
  import cpu_types_pkg::*;
  logic ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, branch_taken, id_jump, ex_halt, wb_halt;
  regbits_t ex_rt, id_rs, id_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, exmem_clear_req;
  modport master (
    input ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, branch_taken, id_jump, ex_halt, wb_halt,
    input ex_rt, id_rs, id_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush, exmem_clear_req
  );
  modport slave (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, branch_taken, id_jump, ex_halt, wb_halt,
    output ex_rt, id_rs, id_rt,
    input pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input ifid_flush, idex_flush, exmem_flush, memwb_flush, exmem_clear_req
  );
endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// hazard_detect: load in ID/EX whose destination feeds an IF/ID source ($0 never hazards)
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     load_use
);
  assign load_use = ex_dREN && ex_rt != '0 && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: per-stage enable/flush sequencing, memory freeze, halt drain and stall statistics
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  pipeline_controller_if.master pif,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      bubble_cycles
);
  ctrl_state_t state, next_state;
  logic lu, freeze, run, drain;
  hazard_detect u_hazard (
    .ex_dREN (pif.ex_dREN),
    .ex_rt   (pif.ex_rt),
    .id_rs   (pif.id_rs),
    .id_rt   (pif.id_rt),
    .load_use(lu)
  );
  // DWAIT keeps the pipe frozen until the clear_req cycle, independent of req
  assign freeze = state != HALTED && (state == DWAIT || pif.mem_dREN || pif.mem_dWEN);
  assign run    = nRST && state != HALTED && !freeze;
  assign drain  = state == DRAIN;
  assign pif.pc_en           = run && !drain && (pif.branch_taken || (!lu && pif.ihit));
  assign pif.ifid_en         = run && (drain || pif.branch_taken || !lu);
  assign pif.idex_en         = run;
  assign pif.exmem_en        = run;
  assign pif.memwb_en        = run;
  assign pif.ifid_flush      = run && (drain || pif.branch_taken || (!lu && (pif.id_jump || !pif.ihit)));
  assign pif.idex_flush      = run && (drain || pif.branch_taken || lu);
  assign pif.exmem_flush     = 1'b0;
  assign pif.memwb_flush     = nRST && freeze;
  assign pif.exmem_clear_req = nRST && freeze && pif.dhit;
  assign halted              = nRST && state == HALTED;
  always_comb
    next_state = pif.wb_halt ? HALTED :
                 state == HALTED ? HALTED :
                 freeze ? (pif.dhit ? ((pif.ex_halt || drain) ? DRAIN : RUN) : DWAIT) :
                 (drain || pif.ex_halt) ? DRAIN : RUN;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state         <= RUN;
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      state <= next_state;
      if (state != HALTED && freeze && !(&stall_cycles))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (state != HALTED && !freeze && (lu || !pif.ihit) && !(&bubble_cycles))
        bubble_cycles <= bubble_cycles + CNT_W'(1);
    end
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed scoreboard bench for the pipeline controller
module tb_pipeline_controller;
  import cpu_types_pkg::*;
  localparam int W = 4;
  localparam logic [10:0] ZERO    = 11'b00000_0000_00;
  localparam logic [10:0] RUNO    = 11'b11111_0000_00;
  localparam logic [10:0] FRZ     = 11'b00000_0001_00;
  localparam logic [10:0] FRZ_CLR = 11'b00000_0001_10;
  localparam logic [10:0] LU      = 11'b00111_0100_00;
  localparam logic [10:0] BR      = 11'b11111_1100_00;
  localparam logic [10:0] JMP     = 11'b11111_1000_00;
  localparam logic [10:0] NOIHIT  = 11'b01111_1000_00;
  localparam logic [10:0] DRN     = 11'b01111_1100_00;
  localparam logic [10:0] HLT     = 11'b00000_0000_01;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic halted;
  logic [W-1:0] stall_cycles, bubble_cycles;
  int total = 0;
  int bad = 0;
  logic [10:0] sb[$];
  pipeline_controller_if pif();
  pipeline_controller #(.CNT_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .pif(pif), .halted(halted),
    .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] obs();
    return {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
            pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush,
            pif.exmem_clear_req, halted};
  endfunction
  task automatic cyc(input string tag, input logic [10:0] exp);
    logic [10:0] e;
    sb.push_back(exp);
    #3;
    e = sb.pop_front();
    chk(tag, 32'(obs()), 32'(e));
    @(posedge CLK);
    #1;
  endtask
  task automatic cnt(input string tag, input logic [W-1:0] s, input logic [W-1:0] b);
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(s));
    chk({tag, "_bubble"}, 32'(bubble_cycles), 32'(b));
  endtask
  initial begin
    pif.ihit = 1; pif.dhit = 0; pif.mem_dREN = 0; pif.mem_dWEN = 0; pif.ex_dREN = 0;
    pif.branch_taken = 0; pif.id_jump = 0; pif.ex_halt = 0; pif.wb_halt = 0;
    pif.ex_rt = 0; pif.id_rs = 0; pif.id_rt = 0;
    #1;
    cyc("reset", ZERO);
    cnt("reset", 0, 0);
    nRST = 1;
    cyc("run", RUNO);
    pif.mem_dREN = 1;
    for (int i = 0; i < 3; i++) cyc("load_wait", FRZ);
    pif.dhit = 1;
    cyc("load_clear", FRZ_CLR);
    pif.mem_dREN = 0; pif.dhit = 0;
    cyc("load_done", RUNO);
    cnt("load", 4, 0);
    pif.ex_dREN = 1; pif.ex_rt = 2; pif.id_rs = 2; pif.id_rt = 4;
    cyc("load_use", LU);
    pif.ex_dREN = 0;
    cyc("lu_done", RUNO);
    cnt("lu", 4, 1);
    pif.ex_dREN = 1; pif.ex_rt = 0; pif.id_rs = 0; pif.id_rt = 0;
    cyc("rt_zero", RUNO);
    pif.ex_dREN = 0;
    cnt("rt_zero", 4, 1);
    pif.branch_taken = 1; pif.ihit = 0;
    cyc("branch_noihit", BR);
    pif.branch_taken = 0; pif.ihit = 1; pif.id_jump = 1;
    cyc("jump", JMP);
    pif.id_jump = 0; pif.ihit = 0;
    cyc("noihit", NOIHIT);
    pif.ihit = 1;
    cnt("bubbles", 4, 3);
    pif.mem_dWEN = 1;
    for (int i = 0; i < 14; i++) cyc("sat_wait", FRZ);
    pif.dhit = 1;
    cyc("sat_clear", FRZ_CLR);
    pif.mem_dWEN = 0; pif.dhit = 0;
    cnt("sat", 15, 3);
    pif.branch_taken = 1; pif.ex_dREN = 1; pif.ex_rt = 5; pif.id_rt = 5;
    cyc("branch_lu", BR);
    pif.branch_taken = 0; pif.ex_dREN = 0;
    pif.mem_dREN = 1;
    cyc("pre_rst_frz", FRZ);
    nRST = 0;
    cyc("rst_dwait", ZERO);
    cnt("rst_dwait", 0, 0);
    nRST = 1; pif.mem_dREN = 0;
    cyc("post_rst", RUNO);
    cnt("post_rst", 0, 0);
    pif.ex_halt = 1;
    cyc("halt_run", RUNO);
    pif.ex_halt = 0;
    cyc("drain1", DRN);
    pif.wb_halt = 1;
    cyc("drain2", DRN);
    pif.wb_halt = 0; pif.ihit = 0; pif.mem_dREN = 1; pif.branch_taken = 1;
    for (int i = 0; i < 3; i++) cyc("halted", HLT);
    cnt("halted", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Sequencer for the five-stage pipeline. It produces the per-stage enable and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It also owns the data-memory freeze and the clearMemReq handshake into EX/MEM, detects load-use hazards, drains the pipe on halt, and keeps stall statistics. It sits beside the datapath, reading stage outputs and driving register controls.

## Interface
Parameters:
- CNT_W, 32, width of the stall and bubble counters.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- mem_dREN, mem_dWEN  in  1 each  EX/MEM register holds a data request (its dREN_out/dWEN_out).
- ex_dREN  in  1  ID/EX holds a load.
- ex_rt  in  5  ID/EX load destination register.
- id_rs, id_rt  in  5 each  IF/ID source registers.
- branch_taken  in  1  branch resolved taken in EX.
- id_jump  in  1  IF/ID holds j/jal/jr.
- ex_halt  in  1  halt_out of ID/EX.
- wb_halt  in  1  halt_out of MEM/WB.
- pc_en  out  1  PC update.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register flushes. Flush overrides enable inside the register.
- exmem_clear_req  out  1  clearMemReq into EX/MEM.
- halted  out  1  core halted.
- stall_cycles, bubble_cycles  out  CNT_W each  saturating statistics.

## Operation
- States: RUN, DWAIT, DRAIN, HALTED. The state register is the only storage besides the counters.
- Default in RUN: all enables 1, all flushes 0, clear_req 0.
- Priority, highest first: HALTED > mem freeze > branch_taken > load-use > id_jump > !ihit. Lower rules OR in only their flushes and only where no higher rule forces the same stage.
- Mem freeze, when req = mem_dREN|mem_dWEN is 1:
  - All enables 0, flushes 0 except memwb_flush = 1, so WB never re-commits.
  - If dhit = 0: next state DWAIT.
  - If dhit = 1: exmem_clear_req = 1, so EX/MEM drops the request and latches load data. Next state RUN, or DRAIN if ex_halt.
- DWAIT: same outputs as mem freeze, driven by req and dhit. The pipe is never released before a clear_req cycle.
- branch_taken:
  - pc_en = 1 regardless of ihit (redirect; the in-flight fetch is discarded).
  - ifid_flush = 1, idex_flush = 1.
- Load-use, when ex_dREN & ex_rt ≠ 0 & (ex_rt == id_rs | ex_rt == id_rt):
  - pc_en = 0, ifid_en = 0, idex_flush = 1. EX/MEM and MEM/WB advance.
- id_jump: ifid_flush = 1.
- !ihit: pc_en = 0, ifid_flush = 1. The downstream stages advance.
- DRAIN: entered from RUN when ex_halt = 1 and no mem freeze.
  - pc_en = 0, ifid_flush = 1, idex_flush = 1. The older stages advance, still subject to mem freeze.
  - When wb_halt = 1, next state HALTED.
- HALTED: all enables 0, all flushes 0, halted = 1. Exit only by reset.
- Counters:
  - stall_cycles increments on every mem-freeze cycle.
  - bubble_cycles increments on every load-use or !ihit cycle that is not a freeze.
  - Both saturate at all-ones and hold in HALTED.

## Timing
- Strobe outputs are combinational from the state and current inputs, with zero latency. State and counters update on the rising edge.
- While nRST = 0, every output is 0 and the state is RUN. Reset asserted mid-freeze returns to RUN with counters 0.
- A load costs at least 1 freeze cycle, the clear_req cycle, even when dhit arrives in the first cycle.
- wb_halt = 1 in any state forces HALTED at the next edge.
- branch_taken in the same cycle as a load-use hazard: the branch wins and the hazard is squashed by idex_flush.

## Structure
- cpu_types_pkg gains ctrl_state_t (2-bit enum: RUN, DWAIT, DRAIN, HALTED). It reuses regbits_t for register indices.
- One combinational sub-module, hazard_detect, computes the load-use term. Everything else lives in pipeline_controller.

## Test plan
- Load with dhit after 3 cycles: 3 cycles with all enables 0 and memwb_flush = 1, then 1 cycle with exmem_clear_req = 1, then all enables 1. stall_cycles = 4.
- lw $2 in ID/EX with add $3,$2,$4 in IF/ID: for 1 cycle pc_en = 0, ifid_en = 0, idex_flush = 1. bubble_cycles = 1.
- branch_taken together with ihit = 0: pc_en = 1, ifid_flush = 1, idex_flush = 1.
- ex_halt = 1, then wb_halt 2 cycles later: DRAIN for 2 cycles, then halted = 1 with all enables 0 permanently.
- ex_rt = 0 with id_rs = 0: no load-use stall.
- nRST pulsed during DWAIT: outputs 0 immediately. After release the controller is in RUN and both counters are 0.
